// File: rtl/alu_pkg.sv
// Shared ALU command encodings, RV32I opcode/funct7 constants and immediate selectors
// for the decode stage and the ALU that consumes its op code.
package alu_pkg;

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b0001;
   localparam logic [3:0] ALU_SLL   = 4'b0010;
   localparam logic [3:0] ALU_SLT   = 4'b0011;
   localparam logic [3:0] ALU_SRL   = 4'b0100;
   localparam logic [3:0] ALU_BEQ   = 4'b0101;
   localparam logic [3:0] ALU_SRA   = 4'b0110;
   localparam logic [3:0] ALU_BNE   = 4'b0111;
   localparam logic [3:0] ALU_AND   = 4'b1000;
   localparam logic [3:0] ALU_BLT   = 4'b1001;
   localparam logic [3:0] ALU_XOR   = 4'b1010;
   localparam logic [3:0] ALU_BGE   = 4'b1011;
   localparam logic [3:0] ALU_OR    = 4'b1100;
   localparam logic [3:0] ALU_PASSB = 4'b1110;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [2:0] {
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_SHAMT
   } imm_sel_e;

   typedef struct packed {
      logic [3:0] op;
      logic       us;
      logic [4:0] rd;
      logic       reg_we;
      logic       is_branch;
      logic       mem_rd;
      logic       mem_wr;
      logic       illegal;
   } alu_ctrl_t;

   // funct3 -> op for the register and immediate arithmetic groups (base funct7).
   function automatic logic [3:0] arith_op(input logic [2:0] funct3);
      logic [3:0] op;
      case (funct3)
         3'b000:  op = ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLT;
         3'b100:  op = ALU_XOR;
         3'b101:  op = ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/alu_op_decoder_imm_gen.sv
// Immediate generator: extracts the I/S/B/U immediate or shift amount from an
// RV32I instruction and sign-extends it to XLEN.
module imm_gen
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:7]     instr,
   input  imm_sel_e        imm_sel,
   output logic [XLEN-1:0] imm
);

   logic [31:0] imm32;

   always_comb begin
      imm32 = '0;
      case (imm_sel)
         IMM_I:     imm32 = {{20{instr[31]}}, instr[31:20]};
         IMM_S:     imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:     imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:     imm32 = {instr[31:12], 12'b0};
         IMM_SHAMT: imm32 = {27'b0, instr[24:20]};
         default:   imm32 = '0;
      endcase
   end

   // Shift amounts are positive, so sign-extending every selector is safe.
   assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/alu_op_decoder.sv
// Registered RV32I decode stage producing the ALU command with valid/ready on both sides.
// Optional ALU_DECODER_ZERO_BYPASS_EN forces operands from x0 to zero.
module alu_op_decoder
   import alu_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter bit NOP_ON_FLUSH = 1'b1
) (
   input  logic            clk_i,
   input  logic            reset_ni,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [31:0]     instr_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   input  logic            flush_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLEN-1:0] alu_a_o,
   output logic [XLEN-1:0] alu_b_o,
   output logic [3:0]      alu_op_o,
   output logic            alu_us_o,
   output logic [XLEN-1:0] imm_o,
   output logic [4:0]      rd_o,
   output logic            reg_we_o,
   output logic            is_branch_o,
   output logic            mem_rd_o,
   output logic            mem_wr_o,
   output logic            illegal_o
);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [4:0]      rd_f;
   imm_sel_e        imm_sel;
   logic [XLEN-1:0] imm_val;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;

   alu_ctrl_t       ctrl_d;
   logic [XLEN-1:0] a_d;
   logic [XLEN-1:0] b_d;
   logic [XLEN-1:0] imm_d;

   alu_ctrl_t       ctrl_q;
   logic [XLEN-1:0] a_q;
   logic [XLEN-1:0] b_q;
   logic [XLEN-1:0] imm_q;

   logic            hs_open;
   logic            capture;

   assign opcode = instr_i[6:0];
   assign rd_f   = instr_i[11:7];
   assign funct3 = instr_i[14:12];
   assign funct7 = instr_i[31:25];

`ifdef ALU_DECODER_ZERO_BYPASS_EN
   assign rs1_val = (instr_i[19:15] == 5'd0) ? '0 : rs1_data_i;
   assign rs2_val = (instr_i[24:20] == 5'd0) ? '0 : rs2_data_i;
`else
   assign rs1_val = rs1_data_i;
   assign rs2_val = rs2_data_i;
`endif

   always_comb begin
      imm_sel = IMM_I;
      case (opcode)
         OPC_OP_IMM:           imm_sel = (funct3 == 3'b001 || funct3 == 3'b101) ? IMM_SHAMT : IMM_I;
         OPC_LUI, OPC_AUIPC:   imm_sel = IMM_U;
         OPC_STORE:            imm_sel = IMM_S;
         OPC_BRANCH:           imm_sel = IMM_B;
         default:              imm_sel = IMM_I;
      endcase
   end

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr   (instr_i[31:7]),
      .imm_sel (imm_sel),
      .imm     (imm_val)
   );

   always_comb begin
      ctrl_d = '0;
      a_d    = '0;
      b_d    = '0;
      imm_d  = '0;
      case (opcode)
         OPC_OP: begin
            a_d           = rs1_val;
            b_d           = rs2_val;
            ctrl_d.reg_we = 1'b1;
            ctrl_d.rd     = rd_f;
            ctrl_d.us     = (funct3 == 3'b011);
            if (funct7 == F7_BASE)
               ctrl_d.op = arith_op(funct3);
            else if (funct7 == F7_ALT && funct3 == 3'b000)
               ctrl_d.op = ALU_SUB;
            else if (funct7 == F7_ALT && funct3 == 3'b101)
               ctrl_d.op = ALU_SRA;
            else
               ctrl_d.illegal = 1'b1;
         end
         OPC_OP_IMM: begin
            a_d           = rs1_val;
            b_d           = imm_val;
            ctrl_d.reg_we = 1'b1;
            ctrl_d.rd     = rd_f;
            ctrl_d.us     = (funct3 == 3'b011);
            ctrl_d.op     = arith_op(funct3);
            // Only the shift encodings constrain funct7; the rest carry immediate bits there.
            if (funct3 == 3'b001 && funct7 != F7_BASE)
               ctrl_d.illegal = 1'b1;
            if (funct3 == 3'b101) begin
               if (funct7 == F7_ALT)
                  ctrl_d.op = ALU_SRA;
               else if (funct7 != F7_BASE)
                  ctrl_d.illegal = 1'b1;
            end
         end
         OPC_LUI: begin
            ctrl_d.op     = ALU_PASSB;
            b_d           = imm_val;
            ctrl_d.reg_we = 1'b1;
            ctrl_d.rd     = rd_f;
         end
         OPC_AUIPC: begin
            ctrl_d.op     = ALU_ADD;
            a_d           = pc_i;
            b_d           = imm_val;
            ctrl_d.reg_we = 1'b1;
            ctrl_d.rd     = rd_f;
         end
         OPC_LOAD: begin
            ctrl_d.op     = ALU_ADD;
            a_d           = rs1_val;
            b_d           = imm_val;
            ctrl_d.mem_rd = 1'b1;
            ctrl_d.reg_we = 1'b1;
            ctrl_d.rd     = rd_f;
         end
         OPC_STORE: begin
            ctrl_d.op     = ALU_ADD;
            a_d           = rs1_val;
            b_d           = imm_val;
            imm_d         = imm_val;
            ctrl_d.mem_wr = 1'b1;
         end
         OPC_BRANCH: begin
            a_d              = rs1_val;
            b_d              = rs2_val;
            imm_d            = imm_val;
            ctrl_d.is_branch = 1'b1;
            case (funct3)
               3'b000:  ctrl_d.op = ALU_BEQ;
               3'b001:  ctrl_d.op = ALU_BNE;
               3'b100:  ctrl_d.op = ALU_BLT;
               3'b101:  ctrl_d.op = ALU_BGE;
               3'b110:  begin ctrl_d.op = ALU_BLT; ctrl_d.us = 1'b1; end
               3'b111:  begin ctrl_d.op = ALU_BGE; ctrl_d.us = 1'b1; end
               default: ctrl_d.illegal = 1'b1;
            endcase
         end
         default: ctrl_d.illegal = 1'b1;
      endcase

      // Illegal entries still travel down the pipe, but as an inert ADD 0,0.
      if (ctrl_d.illegal) begin
         ctrl_d         = '0;
         ctrl_d.illegal = 1'b1;
         a_d            = '0;
         b_d            = '0;
         imm_d          = '0;
      end
      if (ctrl_d.rd == 5'd0)
         ctrl_d.reg_we = 1'b0;
   end

   assign hs_open    = !out_valid_o || out_ready_i;
   assign in_ready_o = hs_open && !(NOP_ON_FLUSH && flush_i);
   assign capture    = in_valid_i && in_ready_o && !flush_i;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         out_valid_o <= 1'b0;
         ctrl_q      <= '0;
         a_q         <= '0;
         b_q         <= '0;
         imm_q       <= '0;
      end else if (flush_i) begin
         if (NOP_ON_FLUSH) begin
            out_valid_o <= 1'b0;
            ctrl_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            imm_q       <= '0;
         end else if (hs_open) begin
            out_valid_o <= 1'b0;
         end
      end else if (capture) begin
         out_valid_o <= 1'b1;
         ctrl_q      <= ctrl_d;
         a_q         <= a_d;
         b_q         <= b_d;
         imm_q       <= imm_d;
      end else if (out_ready_i) begin
         out_valid_o <= 1'b0;
      end
   end

   assign alu_a_o     = a_q;
   assign alu_b_o     = b_q;
   assign imm_o       = imm_q;
   assign alu_op_o    = ctrl_q.op;
   assign alu_us_o    = ctrl_q.us;
   assign rd_o        = ctrl_q.rd;
   assign reg_we_o    = ctrl_q.reg_we;
   assign is_branch_o = ctrl_q.is_branch;
   assign mem_rd_o    = ctrl_q.mem_rd;
   assign mem_wr_o    = ctrl_q.mem_wr;
   assign illegal_o   = ctrl_q.illegal;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Self-checking bench for alu_op_decoder: directed cases followed by random traffic
// compared against a table-driven decode model and a one-entry stage model.
module tb_alu_op_decoder;

   logic        clk_i = 1'b0;
   logic        reset_ni = 1'b0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [31:0] instr_i = '0;
   logic [31:0] pc_i = '0;
   logic [31:0] rs1_data_i = '0;
   logic [31:0] rs2_data_i = '0;
   logic        flush_i = 1'b0;
   logic        out_valid_o;
   logic        out_ready_i = 1'b0;
   logic [31:0] alu_a_o;
   logic [31:0] alu_b_o;
   logic [3:0]  alu_op_o;
   logic        alu_us_o;
   logic [31:0] imm_o;
   logic [4:0]  rd_o;
   logic        reg_we_o;
   logic        is_branch_o;
   logic        mem_rd_o;
   logic        mem_wr_o;
   logic        illegal_o;

   always #5 clk_i = ~clk_i;

   alu_op_decoder dut (
      .clk_i       (clk_i),
      .reset_ni    (reset_ni),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .instr_i     (instr_i),
      .pc_i        (pc_i),
      .rs1_data_i  (rs1_data_i),
      .rs2_data_i  (rs2_data_i),
      .flush_i     (flush_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .alu_a_o     (alu_a_o),
      .alu_b_o     (alu_b_o),
      .alu_op_o    (alu_op_o),
      .alu_us_o    (alu_us_o),
      .imm_o       (imm_o),
      .rd_o        (rd_o),
      .reg_we_o    (reg_we_o),
      .is_branch_o (is_branch_o),
      .mem_rd_o    (mem_rd_o),
      .mem_wr_o    (mem_wr_o),
      .illegal_o   (illegal_o)
   );

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
      logic [3:0]  op;
      logic        us;
      logic [4:0]  rd;
      logic        we;
      logic        br;
      logic        mr;
      logic        mw;
      logic        ill;
   } cmd_t;

   int   total = 0;
   int   bad = 0;
   cmd_t m_cmd = '0;
   logic m_valid = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference decode: lookup tables keyed by funct fields, immediates by arithmetic shifts.
   function automatic cmd_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                       input logic [31:0] r1, input logic [31:0] r2);
      cmd_t        c;
      logic [3:0]  alu_tbl [16];
      logic [3:0]  br_tbl [8];
      int          key;
      int          f3;
      logic [6:0]  f7;
      logic [31:0] ival, sval, bval, uval;
      alu_tbl = '{4'h0, 4'h2, 4'h3, 4'h3, 4'hA, 4'h4, 4'hC, 4'h8,
                  4'h1, 4'hF, 4'hF, 4'hF, 4'hF, 4'h6, 4'hF, 4'hF};
      br_tbl  = '{4'h5, 4'h7, 4'hF, 4'hF, 4'h9, 4'hB, 4'h9, 4'hB};
      f3   = int'(ins[14:12]);
      f7   = ins[31:25];
      ival = 32'($signed(ins) >>> 20);
      sval = (ival & ~32'h1F) | 32'(ins[11:7]);
      bval = (32'($signed(ins) >>> 19) & 32'hFFFF_F000) | (32'(ins[7]) << 11)
             | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      uval = ins & 32'hFFFF_F000;
      c = '0;
      case (ins[6:0])
         7'h33: begin
            c.a = r1; c.b = r2; c.we = 1'b1; c.rd = ins[11:7]; c.us = (f3 == 3);
            key = (f7 == 7'h00) ? f3 : (f7 == 7'h20) ? 8 + f3 : -1;
            c.op = (key < 0) ? 4'hF : alu_tbl[key];
         end
         7'h13: begin
            c.a = r1; c.we = 1'b1; c.rd = ins[11:7]; c.us = (f3 == 3);
            c.b = (f3 == 1 || f3 == 5) ? 32'(ins[24:20]) : ival;
            if (f3 == 1)      key = (f7 == 7'h00) ? 1 : -1;
            else if (f3 == 5) key = (f7 == 7'h00) ? 5 : (f7 == 7'h20) ? 13 : -1;
            else              key = f3;
            c.op = (key < 0) ? 4'hF : alu_tbl[key];
         end
         7'h37: begin c.op = 4'hE; c.b = uval; c.we = 1'b1; c.rd = ins[11:7]; end
         7'h17: begin c.op = 4'h0; c.a = pc; c.b = uval; c.we = 1'b1; c.rd = ins[11:7]; end
         7'h03: begin c.op = 4'h0; c.a = r1; c.b = ival; c.mr = 1'b1; c.we = 1'b1; c.rd = ins[11:7]; end
         7'h23: begin c.op = 4'h0; c.a = r1; c.b = sval; c.imm = sval; c.mw = 1'b1; end
         7'h63: begin
            c.a = r1; c.b = r2; c.br = 1'b1; c.imm = bval;
            c.op = br_tbl[f3]; c.us = (f3 >= 6);
         end
         default: c.op = 4'hF;
      endcase
      if (c.op == 4'hF) begin
         c = '0;
         c.ill = 1'b1;
      end
      if (c.rd == 5'd0) c.we = 1'b0;
      return c;
   endfunction

   task automatic check_outputs();
      check("out_valid", out_valid_o, m_valid);
      check("alu_a", alu_a_o, m_cmd.a);
      check("alu_b", alu_b_o, m_cmd.b);
      check("imm", imm_o, m_cmd.imm);
      check("alu_op", alu_op_o, m_cmd.op);
      check("alu_us", alu_us_o, m_cmd.us);
      check("rd", rd_o, m_cmd.rd);
      check("reg_we", reg_we_o, m_cmd.we);
      check("is_branch", is_branch_o, m_cmd.br);
      check("mem_rd", mem_rd_o, m_cmd.mr);
      check("mem_wr", mem_wr_o, m_cmd.mw);
      check("illegal", illegal_o, m_cmd.ill);
   endtask

   // One clock of traffic: drive, check ready, advance the stage model, check outputs.
   task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic rdy, input logic fl);
      logic exp_ready;
      in_valid_i  = v;
      instr_i     = ins;
      pc_i        = pc;
      rs1_data_i  = r1;
      rs2_data_i  = r2;
      out_ready_i = rdy;
      flush_i     = fl;
      #1;
      exp_ready = !fl && (!m_valid || rdy);
      check("in_ready", in_ready_o, exp_ready);
      if (fl) begin
         m_valid = 1'b0;
         m_cmd   = '0;
      end else if (v && exp_ready) begin
         m_cmd   = ref_decode(ins, pc, r1, r2);
         m_valid = 1'b1;
      end else if (rdy) begin
         m_valid = 1'b0;
      end
      @(posedge clk_i);
      #1;
      check_outputs();
   endtask

   initial begin
      logic [31:0] opc_list [10];
      logic [31:0] r, f7sel, ins;
      logic [6:0]  opc, f7;

      repeat (2) @(posedge clk_i);
      #1;
      check("reset in_ready", in_ready_o, 1'b1);
      check_outputs();
      reset_ni = 1'b1;

      step(1'b1, 32'h402081B3, 32'h100, 32'd10, 32'd3, 1'b1, 1'b0);
      check("sub op", alu_op_o, 4'b0001);
      check("sub a", alu_a_o, 32'd10);
      check("sub b", alu_b_o, 32'd3);
      check("sub rd", rd_o, 5'd3);
      check("sub we", reg_we_o, 1'b1);

      step(1'b1, 32'hFFF0B293, 32'h104, 32'd7, 32'd0, 1'b1, 1'b0);
      check("sltiu op", alu_op_o, 4'b0011);
      check("sltiu us", alu_us_o, 1'b1);
      check("sltiu b", alu_b_o, 32'hFFFF_FFFF);

      step(1'b1, 32'h0020F463, 32'h108, 32'd5, 32'd6, 1'b1, 1'b0);
      check("bgeu op", alu_op_o, 4'b1011);
      check("bgeu us", alu_us_o, 1'b1);
      check("bgeu br", is_branch_o, 1'b1);
      check("bgeu imm", imm_o, 32'd8);
      check("bgeu we", reg_we_o, 1'b0);

      step(1'b1, 32'h123450B7, 32'h10C, 32'd1, 32'd2, 1'b1, 1'b0);
      check("lui op", alu_op_o, 4'b1110);
      check("lui b", alu_b_o, 32'h1234_5000);

      for (int i = 0; i < 3; i++) begin
         step(1'b1, 32'h00208233, 32'h110, 32'd4, 32'd4, 1'b0, 1'b0);
         check("hold in_ready", in_ready_o, 1'b0);
         check("hold valid", out_valid_o, 1'b1);
         check("hold b", alu_b_o, 32'h1234_5000);
         check("hold op", alu_op_o, 4'b1110);
      end
      step(1'b1, 32'h00208233, 32'h110, 32'd4, 32'd4, 1'b0, 1'b1);
      check("flush valid", out_valid_o, 1'b0);

      step(1'b1, 32'h0000006F, 32'h114, 32'd9, 32'd9, 1'b1, 1'b0);
      check("jal illegal", illegal_o, 1'b1);
      check("jal we", reg_we_o | mem_rd_o | mem_wr_o | is_branch_o, 1'b0);
      check("jal op", alu_op_o, 4'b0000);

      step(1'b1, 32'h402081B3, 32'h118, 32'd10, 32'd3, 1'b0, 1'b0);
      #2;
      reset_ni = 1'b0;
      #1;
      check("rst valid", out_valid_o, 1'b0);
      check("rst a", alu_a_o, 32'd0);
      check("rst op", alu_op_o, 4'd0);
      check("rst rd", rd_o, 5'd0);
      check("rst we", reg_we_o, 1'b0);
      m_valid    = 1'b0;
      m_cmd      = '0;
      in_valid_i = 1'b0;
      @(negedge clk_i);
      reset_ni = 1'b1;
      #1;
      check("rst in_ready", in_ready_o, 1'b1);

      opc_list = '{32'h33, 32'h13, 32'h37, 32'h17, 32'h03, 32'h23, 32'h63, 32'h6F, 32'h67, 32'h73};
      for (int i = 0; i < 1500; i++) begin
         r     = $urandom();
         f7sel = $urandom_range(0, 2);
         opc   = 7'(opc_list[$urandom_range(0, 9)]);
         if ($urandom_range(0, 19) == 0) opc = 7'($urandom());
         f7 = (f7sel == 0) ? 7'h00 : (f7sel == 1) ? 7'h20 : 7'($urandom());
         ins = {f7, r[24:7], opc};
         step($urandom_range(0, 3) != 0, ins, $urandom(), $urandom(), $urandom(),
              $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
